uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, 868 at defaults).
REQ-003 SHALL have parameter DATA_BITS, default 8, legal range 5..9, payload bits per frame.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, power of two >= 2, receive buffer entries.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port m_data  output  DATA_BITS  head-of-FIFO payload.
REQ-010 SHALL have port m_frame_err  output  1  stop-bit error flag of head entry.
REQ-011 SHALL have port m_parity_err  output  1  parity error flag of head entry (0 when PARITY=0).
REQ-012 SHALL have port m_valid  output  1  FIFO non-empty; head entry presented.
REQ-013 SHALL have port m_ready  input  1  consumer accepts head entry.
REQ-014 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held.
REQ-015 SHALL have port overrun  output  1  sticky: frame dropped because FIFO full.
REQ-016 SHALL have port clear_overrun  input  1  clears overrun.

Function
REQ-017 SHALL pass rx through a 2-flop synchronizer, both flops reset to 1; all decisions use the synchronized value.
REQ-018 SHALL take each bit value as majority of 3 samples at bit-counter values CLKS_PER_BIT/2-1, CLKS_PER_BIT/2, CLKS_PER_BIT/2+1.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-020 IDLE: synchronized rx = 0 -> START, bit counter cleared.
REQ-021 START: majority 0 at mid-bit -> DATA; majority 1 -> IDLE (glitch rejected, nothing pushed).
REQ-022 DATA: one bit per CLKS_PER_BIT, LSB first; after DATA_BITS bits -> PARITY if PARITY!=0, else STOP.
REQ-023 PARITY: sampled bit compared against odd/even parity of payload; mismatch sets the entry's parity_err -> STOP.
REQ-024 STOP: at mid-bit sample, push {parity_err, frame_err, data}; stop=1 -> IDLE same cycle (back-to-back frames supported); stop=0 -> frame_err=1, push, -> WAIT_HIGH.
REQ-025 WAIT_HIGH: remain until synchronized rx = 1, then IDLE; a held-low line (break) yields exactly one entry.
REQ-026 FIFO SHALL be first-word-fall-through: m_valid and head fields update the cycle after the push cycle when empty.
REQ-027 Pop SHALL occur on a cycle with m_valid && m_ready; m_ready with m_valid=0 has no effect.
REQ-028 Push when full and no pop that cycle: entry dropped, contents unchanged, overrun set to 1.
REQ-029 Simultaneous push and pop when full: both performed, fifo_count unchanged, overrun not set.
REQ-030 Simultaneous push and pop when empty: push accepted, pop ignored.
REQ-031 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL reach exactly FIFO_DEPTH.
REQ-032 clear_overrun asserted the same cycle as a new overrun: overrun SHALL end that cycle at 1 (set wins).

Reset
REQ-033 On reset: state IDLE, counters 0, FIFO emptied, m_valid=0, fifo_count=0, overrun=0, m_data/m_frame_err/m_parity_err=0.
REQ-034 Reset mid-frame SHALL discard the partial frame; reception restarts only on a new falling edge after reset deasserts.

Verification
REQ-035 Defaults, m_ready=1, send 0x55 then 0xAA back-to-back at 115200 -> two entries 0x55, 0xAA, both error flags 0, overrun 0.
REQ-036 PARITY=2, send 0xA5 with parity bit 1 -> m_data=0xA5, m_parity_err=1; parity bit 0 -> m_parity_err=0.
REQ-037 Send 0x21 with stop bit 0, rx held low 3 bit-times -> exactly one entry, m_data=0x21, m_frame_err=1.
REQ-038 rx low pulse of 200 ns while idle -> no entry, state back to IDLE, fifo_count=0.
REQ-039 m_ready=0, send 17 frames 0x00..0x10 -> fifo_count=16, overrun=1, entries 0x00..0x0F read in order; clear_overrun -> overrun=0.
REQ-040 Assert reset midway through DATA bit 4 of a frame -> no entry, all outputs at reset values; next full frame 0x3E received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with a first-word-fall-through receive FIFO.
//
// Each frame is a start bit, DATA_BITS payload bits (LSB first), an optional parity bit and a
// stop bit. Every bit is the majority of three samples taken around mid-bit. A finished frame
// is pushed as {parity_err, frame_err, data}. If the FIFO is full and nothing is popped in the
// same cycle, the frame is dropped and the sticky overrun flag is set.
//
// Ports:
//   clk           in   sole clock, rising edge
//   reset         in   synchronous, active-high reset
//   rx            in   asynchronous serial line, idle high
//   m_data        out  head-of-FIFO payload (0 when empty)
//   m_frame_err   out  stop-bit error flag of the head entry
//   m_parity_err  out  parity error flag of the head entry
//   m_valid       out  FIFO non-empty, head entry presented
//   m_ready       in   consumer accepts the head entry
//   fifo_count    out  number of entries held
//   overrun       out  sticky: a frame was dropped because the FIFO was full
//   clear_overrun in   clears overrun; a new overrun in the same cycle takes priority
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_frame_err,
  output logic                          m_parity_err,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          clear_overrun
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam int unsigned IdxW       = $clog2(DATA_BITS + 1);
  localparam int unsigned AddrW      = $clog2(FIFO_DEPTH);
  localparam int unsigned EntW       = DATA_BITS + 2;

  localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] SampleA = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] SampleB = CntW'(ClksPerBit / 2);
  localparam logic [CntW-1:0] SampleC = CntW'(ClksPerBit / 2 + 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StStart    = 3'd1;
  localparam logic [2:0] StData     = 3'd2;
  localparam logic [2:0] StParity   = 3'd3;
  localparam logic [2:0] StStop     = 3'd4;
  localparam logic [2:0] StWaitHigh = 3'd5;

  // Input synchronizer and start-arming.
  logic       rx_meta_q, rx_sync_q;
  logic [1:0] settle_q;
  logic       armed_q;

  // settle_q marks when rx_sync_q reflects the line rather than its reset value. Reception is
  // only armed once the line has been seen high, so a line that is low when reset releases
  // (a frame cut by reset) cannot start a bogus frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      settle_q  <= 2'b00;
      armed_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      settle_q  <= {settle_q[0], 1'b1};
      armed_q   <= armed_q | (settle_q[1] & rx_sync_q);
    end
  end

  // Receiver FSM.
  logic [2:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           vote_q, vote_d;
  logic                 perr_q, perr_d;
  logic                 bit_tick, bit_val, exp_par;
  logic                 push;
  logic [EntW-1:0]      push_entry;

  assign bit_tick = (cnt_q == SampleC);
  // Third sample is the live synchronized value; the first two were latched earlier.
  assign bit_val  = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_sync_q) | (vote_q[1] & rx_sync_q);
  assign exp_par  = (PARITY == 1) ? ~(^shift_q) : (^shift_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
    idx_d      = idx_q;
    shift_d    = shift_q;
    vote_d     = vote_q;
    perr_d     = perr_q;
    push       = 1'b0;
    push_entry = {perr_q, 1'b0, shift_q};

    if (cnt_q == SampleA) vote_d[0] = rx_sync_q;
    if (cnt_q == SampleB) vote_d[1] = rx_sync_q;

    case (state_q)
      StIdle: begin
        cnt_d  = '0;
        idx_d  = '0;
        perr_d = 1'b0;
        if (armed_q && !rx_sync_q) state_d = StStart;
      end
      StStart: begin
        if (bit_tick) state_d = bit_val ? StIdle : StData;
      end
      StData: begin
        if (bit_tick) begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IdxW'(1);
          if (idx_q == IdxLast) state_d = (PARITY != 0) ? StParity : StStop;
        end
      end
      StParity: begin
        if (bit_tick) begin
          perr_d  = (bit_val != exp_par);
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_tick) begin
          push       = 1'b1;
          push_entry = {perr_q, ~bit_val, shift_q};
          // Leaving at mid-stop lets a back-to-back start edge be caught.
          state_d    = bit_val ? StIdle : StWaitHigh;
        end
      end
      StWaitHigh: begin
        if (rx_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      vote_q  <= 2'b11;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      vote_q  <= vote_d;
      perr_q  <= perr_d;
    end
  end

  // Receive FIFO (first-word-fall-through).
  logic [EntW-1:0]  mem_q [FIFO_DEPTH];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [AddrW:0]   count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             full, pop, push_ok;
  logic [EntW-1:0]  head;

  assign full    = (count_q == (AddrW + 1)'(FIFO_DEPTH));
  assign m_valid = (count_q != '0);
  assign pop     = m_valid & m_ready;
  // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
  assign push_ok = push & (~full | pop);
  assign head    = mem_q[rptr_q];

  always_comb begin
    count_d = count_q + (AddrW + 1)'(push_ok) - (AddrW + 1)'(pop);
    if (push && full && !pop) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AddrW'(1);
      if (pop)     rptr_q <= rptr_q + AddrW'(1);
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_data       = m_valid ? head[DATA_BITS-1:0] : '0;
  assign m_frame_err  = m_valid & head[DATA_BITS];
  assign m_parity_err = m_valid & head[DATA_BITS+1];
  assign fifo_count   = count_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: instance A has no parity, instance B even parity.
module tb_uart_rx_fifo;

  localparam int unsigned ClkFreq = 100_000_000;
  localparam int unsigned Baud    = 1_562_500;
  localparam int unsigned Cpb     = ClkFreq / Baud;  // 64 clocks per bit
  localparam int unsigned Depth   = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic m_ready = 1'b1;
  logic clear_overrun = 1'b0;

  logic [7:0] m_data_a, m_data_b;
  logic       fe_a, fe_b, pe_a, pe_b, m_valid_a, m_valid_b, overrun_a, overrun_b;
  logic [4:0] fifo_count_a, fifo_count_b;

  uart_rx_fifo #(
    .CLK_FREQ(ClkFreq), .BAUD(Baud), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(Depth)
  ) dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .m_data(m_data_a), .m_frame_err(fe_a),
    .m_parity_err(pe_a), .m_valid(m_valid_a), .m_ready(m_ready), .fifo_count(fifo_count_a),
    .overrun(overrun_a), .clear_overrun(clear_overrun)
  );

  uart_rx_fifo #(
    .CLK_FREQ(ClkFreq), .BAUD(Baud), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(Depth)
  ) dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .m_data(m_data_b), .m_frame_err(fe_b),
    .m_parity_err(pe_b), .m_valid(m_valid_b), .m_ready(m_ready), .fifo_count(fifo_count_b),
    .overrun(overrun_b), .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  bit model_ovr_a = 1'b0;
  bit rnd_ready = 1'b0;
  bit watch = 1'b0;
  bit ovr_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected entry {parity_err, frame_err, data} from frame contents.
  function automatic logic [9:0] model_entry(input logic [7:0] d, input bit par_en,
                                             input bit pbit, input bit stopb);
    bit good_par;
    bit pe;
    good_par = ($countones(d) % 2) == 1;  // even parity: total ones incl. parity bit even
    pe = par_en && (pbit != good_par);
    return {pe, ~stopb, d};
  endfunction

  // Monitors: pop the scoreboard whenever an instance hands over an entry.
  always @(negedge clk) begin
    if (!reset && m_valid_a && m_ready) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_spurious_entry: got %0h expected none", {pe_a, fe_a, m_data_a});
      end else begin
        chk("a_entry", {pe_a, fe_a, m_data_a}, q_a.pop_front());
      end
    end
    if (!reset && m_valid_b && m_ready) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_spurious_entry: got %0h expected none", {pe_b, fe_b, m_data_b});
      end else begin
        chk("b_entry", {pe_b, fe_b, m_data_b}, q_b.pop_front());
      end
    end
    if (watch) ovr_seen = ovr_seen | overrun_a;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit to_b, input bit v);
    if (to_b) rx_b = v;
    else rx_a = v;
    wait_cyc(Cpb);
  endtask

  task automatic send_frame(input bit to_b, input logic [7:0] d, input bit pbit,
                            input bit stopb, input int low_after);
    logic [9:0] e;
    e = model_entry(d, to_b, pbit, stopb);
    if (to_b) q_b.push_back(e);
    else if (q_a.size() >= Depth) model_ovr_a = 1'b1;
    else q_a.push_back(e);
    drive_bit(to_b, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(to_b, d[i]);
    if (to_b) drive_bit(to_b, pbit);
    drive_bit(to_b, stopb);
    if (!stopb) begin
      wait_cyc(low_after * Cpb);
      if (to_b) rx_b = 1'b1;
      else rx_a = 1'b1;
      wait_cyc(2 * Cpb);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 4000) begin
      wait_cyc(1);
      n++;
    end
    chk("drain_pending", q_a.size() + q_b.size(), 0);
    q_a.delete();
    q_b.delete();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    bit pb, sb;

    wait_cyc(5);
    chk("rst_valid", m_valid_a, 0);
    chk("rst_count", fifo_count_a, 0);
    chk("rst_overrun", overrun_a, 0);
    chk("rst_outputs", {pe_a, fe_a, m_data_a}, 0);
    reset = 1'b0;
    wait_cyc(10);

    // Back-to-back frames, no parity.
    send_frame(1'b0, 8'h55, 1'b0, 1'b1, 0);
    send_frame(1'b0, 8'hAA, 1'b0, 1'b1, 0);
    wait_drain();
    chk("b2b_overrun", overrun_a, 0);
    chk("b2b_count", fifo_count_a, 0);

    // Even parity: wrong then right parity bit.
    send_frame(1'b1, 8'hA5, 1'b1, 1'b1, 0);
    send_frame(1'b1, 8'hA5, 1'b0, 1'b1, 0);
    wait_drain();

    // Bad stop bit with the line held low three bit-times.
    send_frame(1'b0, 8'h21, 1'b0, 1'b0, 2);
    wait_drain();
    wait_cyc(Cpb);
    chk("break_count", fifo_count_a, 0);

    // 200 ns glitch while idle.
    rx_a = 1'b0;
    wait_cyc(20);
    rx_a = 1'b1;
    wait_cyc(3 * Cpb);
    chk("glitch_count", fifo_count_a, 0);
    chk("glitch_valid", m_valid_a, 0);
    send_frame(1'b0, 8'h96, 1'b0, 1'b1, 0);
    wait_drain();

    // Random frames with a randomly stalling consumer.
    rnd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      send_frame(1'b0, d, 1'b0, 1'b1, 0);
      d  = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 3) != 0);
      send_frame(1'b1, d, pb, sb, 0);
    end
    rnd_ready = 1'b0;
    wait_cyc(2);
    m_ready = 1'b1;
    wait_drain();

    // Overrun: 17 frames into a 16-entry FIFO with no consumer.
    m_ready = 1'b0;
    wait_cyc(2);
    for (int i = 0; i <= 16; i++) send_frame(1'b0, 8'(i), 1'b0, 1'b1, 0);
    chk("ovr_count", fifo_count_a, q_a.size());
    chk("ovr_full", fifo_count_a, Depth);
    chk("ovr_flag", overrun_a, model_ovr_a);
    clear_overrun = 1'b1;
    wait_cyc(1);
    clear_overrun = 1'b0;
    wait_cyc(1);
    chk("ovr_cleared", overrun_a, 0);
    // Dropped frame while clear is held: the set must win for that cycle.
    ovr_seen = 1'b0;
    watch = 1'b1;
    clear_overrun = 1'b1;
    send_frame(1'b0, 8'h11, 1'b0, 1'b1, 0);
    watch = 1'b0;
    clear_overrun = 1'b0;
    chk("ovr_set_wins", ovr_seen, 1);
    chk("ovr_count_kept", fifo_count_a, Depth);
    m_ready = 1'b1;
    wait_drain();
    wait_cyc(2);
    chk("ovr_drained", fifo_count_a, 0);

    // Reset in the middle of data bit 4 of a frame of zeros.
    rx_a = 1'b0;
    wait_cyc(5 * Cpb + Cpb / 2);
    reset = 1'b1;
    wait_cyc(3);
    chk("midrst_count", fifo_count_a, 0);
    chk("midrst_outputs", {m_valid_a, overrun_a, pe_a, fe_a, m_data_a}, 0);
    reset = 1'b0;
    wait_cyc(Cpb / 2 - 3 + 3 * Cpb);
    rx_a = 1'b1;
    wait_cyc(3 * Cpb);
    chk("midrst_none", fifo_count_a, 0);
    chk("midrst_valid", m_valid_a, 0);
    send_frame(1'b0, 8'h3E, 1'b0, 1'b1, 0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
